// File: rtl/button_conditioner_if.sv
// Bundle of raw switch inputs and conditioned outputs for button_conditioner.
// Ports: master drives the *_raw signals; slave (the conditioner) drives levels,
//   pulses, captured sel/value, param_strobe and stuck flags.
interface button_conditioner_if;
    logic       sensor_raw;
    logic       walk_raw;
    logic       prog_raw;
    logic [1:0] sel_raw;
    logic [3:0] value_raw;

    logic       sensor_level;
    logic       walk_level;
    logic       prog_level;
    logic       walk_pulse;
    logic       prog_pulse;
    logic [1:0] sel_out;
    logic [3:0] value_out;
    logic       param_strobe;
    logic [2:0] stuck;

    modport master (
        output sensor_raw, walk_raw, prog_raw, sel_raw, value_raw,
        input  sensor_level, walk_level, prog_level,
        input  walk_pulse, prog_pulse,
        input  sel_out, value_out, param_strobe, stuck
    );

    modport slave (
        input  sensor_raw, walk_raw, prog_raw, sel_raw, value_raw,
        output sensor_level, walk_level, prog_level,
        output walk_pulse, prog_pulse,
        output sel_out, value_out, param_strobe, stuck
    );
endinterface

// File: rtl/button_conditioner.sv
// Switch conditioner: two-flop synchronizers, per-channel debounce, rising-edge
// pulses for walk/prog, sel/value capture on a prog press, optional stuck flags.
// Ports: clock, reset (async active-low), bus (button_conditioner_if.slave):
//   raw in: sensor_raw, walk_raw, prog_raw, sel_raw[1:0], value_raw[3:0]
//   out:    sensor/walk/prog_level, walk/prog_pulse, sel_out, value_out,
//           param_strobe, stuck[2:0] (bit0 sensor, bit1 walk, bit2 prog)
// Macro STUCK_DETECT_EN: when defined, each channel counts cycles spent high
//   and raises its stuck bit after STUCK_CYCLES; otherwise stuck is 3'b000.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic                clock,
    input  logic                reset,
    button_conditioner_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Synchronizer word layout: {value[3:0], sel[1:0], prog, walk, sensor}
    logic [8:0] raw_w;
    logic [8:0] meta_q;
    logic [8:0] sync_q;

    assign raw_w = {
        bus.value_raw,
        bus.sel_raw,
        bus.prog_raw,
        bus.walk_raw,
        bus.sensor_raw
    };

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_w;
            sync_q <= meta_q;
        end
    end

    // Debounced levels: lvl_q is the registered level, lvl_nxt the value it
    // takes on the coming edge (used for same-edge pulse and capture).
    logic [2:0] lvl_q;
    logic [2:0] lvl_nxt;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_nxt;
        logic          l_q;
        logic          l_nxt;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                l_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_nxt;
                l_q   <= l_nxt;
            end
        end

        // Any sample equal to the level restarts the run, so glitches in
        // the opposite direction are never accumulated.
        always_comb begin
            cnt_nxt = '0;
            l_nxt   = l_q;
            if (sync_q[ch] != l_q) begin
                if (cnt_q == CNT_LAST) begin
                    l_nxt = ~l_q;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
        end

        assign lvl_q[ch]   = l_q;
        assign lvl_nxt[ch] = l_nxt;
    end

    logic walk_rise;
    logic prog_rise;

    assign walk_rise = lvl_nxt[1] & ~lvl_q[1];
    assign prog_rise = lvl_nxt[2] & ~lvl_q[2];

    logic       walk_pulse_q;
    logic       prog_pulse_q;
    logic       strobe_q;
    logic [1:0] sel_q;
    logic [3:0] value_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            walk_pulse_q <= 1'b0;
            prog_pulse_q <= 1'b0;
            strobe_q     <= 1'b0;
            sel_q        <= '0;
            value_q      <= '0;
        end else begin
            walk_pulse_q <= walk_rise;
            prog_pulse_q <= prog_rise;
            strobe_q     <= prog_rise;
            if (prog_rise) begin
                sel_q   <= sync_q[4:3];
                value_q <= sync_q[8:5];
            end
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] HI_MAX = SW'(STUCK_CYCLES);

    logic [2:0] stuck_w;

    for (genvar ch = 0; ch < 3; ch++) begin : g_stuck
        logic [SW-1:0] hi_q;
        logic [SW-1:0] hi_nxt;
        logic          st_q;

        // Count starts on the first edge after the level is already high,
        // saturates, and drops on the same edge the level falls.
        always_comb begin
            hi_nxt = hi_q;
            if (!lvl_nxt[ch]) begin
                hi_nxt = '0;
            end else if (lvl_q[ch] && (hi_q != HI_MAX)) begin
                hi_nxt = hi_q + SW'(1);
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                hi_q <= '0;
                st_q <= 1'b0;
            end else begin
                hi_q <= hi_nxt;
                st_q <= (hi_nxt == HI_MAX);
            end
        end

        assign stuck_w[ch] = st_q;
    end

    assign bus.stuck = stuck_w;
`else
    // Stuck detection compiled out; the threshold is accepted but ignored.
    logic [31:0] unused_stuck_cfg;
    assign unused_stuck_cfg = STUCK_CYCLES;
    assign bus.stuck        = 3'b000;
`endif

    assign bus.sensor_level = lvl_q[0];
    assign bus.walk_level   = lvl_q[1];
    assign bus.prog_level   = lvl_q[2];
    assign bus.walk_pulse   = walk_pulse_q;
    assign bus.prog_pulse   = prog_pulse_q;
    assign bus.param_strobe = strobe_q;
    assign bus.sel_out      = sel_q;
    assign bus.value_out    = value_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed switch scenarios, a per-cycle
// reference model of the debounce rules, and hand-computed edge checks.
module tb_button_conditioner;
    localparam int D = 4;
    localparam int S = 20;
`ifdef STUCK_DETECT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .STUCK_CYCLES(S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_word();
        return {bus.sensor_level, bus.walk_level, bus.prog_level,
                bus.walk_pulse, bus.prog_pulse, bus.param_strobe,
                bus.sel_out, bus.value_out, bus.stuck};
    endfunction

    // Reference model: raw samples reach the debouncer two edges late; a
    // level flips after D consecutive differing samples.
    logic [8:0] pipe[$];
    bit         mlvl[3];
    int         mrun[3];
    int         mhi[3];
    bit         mrose[3];
    logic [1:0] msel;
    logic [3:0] mval;

    function automatic logic [14:0] exp_word();
        logic [2:0] st;
        for (int c = 0; c < 3; c++)
            st[c] = SE && mlvl[c] && (mhi[c] >= S);
        return {mlvl[0], mlvl[1], mlvl[2], mrose[1], mrose[2], mrose[2],
                msel, mval, st};
    endfunction

    task automatic model_clear();
        pipe.delete();
        pipe.push_back(9'd0);
        pipe.push_back(9'd0);
        for (int c = 0; c < 3; c++) begin
            mlvl[c] = 0; mrun[c] = 0; mhi[c] = 0; mrose[c] = 0;
        end
        msel = '0;
        mval = '0;
    endtask

    task automatic model_step(input logic [8:0] seen);
        for (int c = 0; c < 3; c++) begin
            mrose[c] = 0;
            if (seen[c] != mlvl[c]) begin
                mrun[c]++;
                if (mrun[c] == D) begin
                    mlvl[c] = ~mlvl[c];
                    mrun[c] = 0;
                    mrose[c] = mlvl[c];
                end
            end else begin
                mrun[c] = 0;
            end
            if (!mlvl[c]) mhi[c] = 0;
            else if (!mrose[c] && mhi[c] < S) mhi[c]++;
        end
        if (mrose[2]) begin
            msel = seen[4:3];
            mval = seen[8:5];
        end
    endtask

    initial begin
        logic [8:0] seen;
        model_clear();
        forever begin
            @(posedge clock);
            if (!reset) begin
                model_clear();
            end else begin
                seen = pipe.pop_front();
                pipe.push_back({bus.value_raw, bus.sel_raw, bus.prog_raw,
                                bus.walk_raw, bus.sensor_raw});
                model_step(seen);
            end
            #1;
            chk("outputs", 32'(dut_word()), 32'(exp_word()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic clear_raw();
        bus.sensor_raw = 0;
        bus.walk_raw   = 0;
        bus.prog_raw   = 0;
        bus.sel_raw    = '0;
        bus.value_raw  = '0;
    endtask

    // Leaves time just after reset release; the next edge is edge 1.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_async", 32'(dut_word()), 0);
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        int npulse;
        logic [39:0] bounce;
        clear_raw();
        #1;
        do_reset();

        // Clean walk step sampled at edge 10
        tick(9);
        bus.walk_raw = 1;
        tick(5);
        chk("a_lvl_e14", 32'(bus.walk_level), 0);
        tick(1);
        chk("a_lvl_e15", 32'(bus.walk_level), 1);
        chk("a_pls_e15", 32'(bus.walk_pulse), 1);
        tick(1);
        chk("a_pls_e16", 32'(bus.walk_pulse), 0);
        bus.walk_raw = 0;
        tick(5);
        chk("a_fall_e21", 32'(bus.walk_level), 1);
        tick(1);
        chk("a_fall_e22", 32'(bus.walk_level), 0);
        chk("a_nopls", 32'(bus.walk_pulse), 0);

        // Glitch low at edge 13 restarts the count
        clear_raw();
        do_reset();
        tick(9);
        bus.walk_raw = 1;
        tick(3);
        bus.walk_raw = 0;
        tick(1);
        bus.walk_raw = 1;
        npulse = 0;
        for (int e = 14; e <= 30; e++) begin
            tick(1);
            if (bus.walk_pulse) npulse++;
            if (e == 18) chk("b_lvl_e18", 32'(bus.walk_level), 0);
            if (e == 19) chk("b_lvl_e19", 32'(bus.walk_level), 1);
        end
        chk("b_npulse", 32'(npulse), 1);

        // Parameter capture on prog press
        clear_raw();
        bus.sel_raw   = 2'b10;
        bus.value_raw = 4'h7;
        do_reset();
        tick(9);
        bus.prog_raw = 1;
        tick(5);
        chk("c_strobe_e14", 32'(bus.param_strobe), 0);
        tick(1);
        chk("c_sel_e15", 32'(bus.sel_out), 2);
        chk("c_val_e15", 32'(bus.value_out), 7);
        chk("c_strobe_e15", 32'(bus.param_strobe), 1);
        tick(1);
        chk("c_strobe_e16", 32'(bus.param_strobe), 0);
        bus.value_raw = 4'h3;
        bus.sel_raw   = 2'b01;
        tick(8);
        chk("c_val_hold", 32'(bus.value_out), 7);
        chk("c_sel_hold", 32'(bus.sel_out), 2);

        // Reset mid-count on the sensor channel
        clear_raw();
        do_reset();
        tick(9);
        bus.sensor_raw = 1;
        tick(2);
        do_reset();
        tick(5);
        chk("d_lvl_r5", 32'(bus.sensor_level), 0);
        tick(1);
        chk("d_lvl_r6", 32'(bus.sensor_level), 1);

        // Sensor held high long enough to be flagged stuck
        clear_raw();
        do_reset();
        tick(9);
        bus.sensor_raw = 1;
        tick(6);
        chk("e_lvl_e15", 32'(bus.sensor_level), 1);
        tick(19);
        chk("e_stuck_e34", 32'(bus.stuck), 0);
        tick(1);
        chk("e_stuck_e35", 32'(bus.stuck), 32'(SE));
        tick(14);
        bus.sensor_raw = 0;
        tick(5);
        chk("e_stuck_e54", 32'(bus.stuck), 32'(SE));
        tick(1);
        chk("e_lvl_e55", 32'(bus.sensor_level), 0);
        chk("e_stuck_e55", 32'(bus.stuck), 0);

        // All channels rise together
        clear_raw();
        bus.sel_raw   = 2'b01;
        bus.value_raw = 4'hA;
        do_reset();
        tick(9);
        bus.sensor_raw = 1;
        bus.walk_raw   = 1;
        bus.prog_raw   = 1;
        tick(5);
        chk("f_e14", 32'(dut_word()), 0);
        tick(1);
        chk("f_e15", 32'(dut_word() >> 9), 32'h3F);
        chk("f_val_e15", 32'(bus.value_out), 32'hA);
        tick(1);
        chk("f_e16", 32'(dut_word() >> 9), 32'h38);

        // Walk held high through reset release
        clear_raw();
        bus.walk_raw = 1;
        do_reset();
        tick(5);
        chk("g_lvl_r5", 32'(bus.walk_level), 0);
        tick(1);
        chk("g_lvl_r6", 32'(bus.walk_level), 1);
        chk("g_pls_r6", 32'(bus.walk_pulse), 1);

        // Bouncy pattern on walk and prog, checked by the model only
        clear_raw();
        do_reset();
        bounce = 40'hF0_F7_BF_E0_3D;
        for (int i = 0; i < 40; i++) begin
            bus.walk_raw  = bounce[i];
            bus.prog_raw  = ~bounce[39 - i];
            bus.value_raw = 4'(i);
            bus.sel_raw   = 2'(i >> 2);
            tick(1);
        end
        clear_raw();
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive cycles a synchronized input must differ from its debounced level before the level changes; legal range 2..65535.
REQ-002 Parameter STUCK_CYCLES, default 1024: number of cycles a debounced level may stay high before it is flagged stuck; legal range greater than DEBOUNCE_CYCLES, up to 2^20.
REQ-003 clock  input  1  single system clock; all flops are rising-edge triggered.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sensor_raw, walk_raw, prog_raw  input  1 each  raw asynchronous switch inputs, active-high.
REQ-006 sel_raw  input  2  raw time-parameter selector switches.
REQ-007 value_raw  input  4  raw time-value switches.
REQ-008 sensor_level, walk_level, prog_level  output  1 each  debounced levels.
REQ-009 walk_pulse, prog_pulse  output  1 each  one-cycle pulses on a debounced rising edge.
REQ-010 sel_out  output  2  and  value_out  output  4  parameter fields captured on a prog rising edge.
REQ-011 param_strobe  output  1  one-cycle pulse marking that sel_out/value_out were updated.
REQ-012 stuck  output  3  per-channel stuck flags: bit0 sensor, bit1 walk, bit2 prog.

Function
REQ-013 Each raw 1-bit input and each bit of sel_raw/value_raw SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each channel SHALL hold a debounced level L and a counter C of width clog2(DEBOUNCE_CYCLES).
REQ-015 When the synchronized input equals L, C SHALL be cleared to 0 on that edge.
REQ-016 When the synchronized input differs from L and C < DEBOUNCE_CYCLES-1, C SHALL increment.
REQ-017 When the synchronized input differs from L and C = DEBOUNCE_CYCLES-1, L SHALL toggle and C SHALL clear on that edge.
REQ-018 A single-cycle glitch in the opposite direction SHALL restart the count from 0; it SHALL NOT be accumulated.
REQ-019 Latency: a clean raw step sampled at edge k SHALL change the debounced level output at edge k+1+DEBOUNCE_CYCLES.
REQ-020 walk_pulse and prog_pulse SHALL be high in exactly the cycle in which their level first reads 1, and for one cycle only; a falling edge SHALL produce no pulse.
REQ-021 sensor SHALL provide a level output only.
REQ-022 On the edge where prog_level rises, sel_out and value_out SHALL load the synchronized sel/value, and param_strobe SHALL assert for that same cycle.
REQ-023 sel_out and value_out SHALL hold their values between strobes regardless of sel_raw/value_raw.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on all channels SHALL each be processed in the same cycles as if they were alone.

Reset
REQ-025 While reset is low, all synchronizer flops, L, C, sel_out, value_out, stuck counters and stuck SHALL be 0, asynchronously.
REQ-026 All pulses SHALL be 0 during reset.
REQ-027 An input held high through reset release SHALL be debounced from zero, giving a level at edge 2+DEBOUNCE_CYCLES after release with a normal pulse.
REQ-028 A reset asserted mid-count SHALL discard the count and SHALL NOT emit a pulse.

Configuration
REQ-029 Macro STUCK_DETECT_EN defined: each channel SHALL have a saturating counter that counts cycles while L=1 and clears when L=0.
REQ-030 With STUCK_DETECT_EN defined, the channel's stuck bit SHALL set when its counter reaches STUCK_CYCLES and SHALL clear on the edge L returns to 0.
REQ-031 With STUCK_DETECT_EN defined, stuck SHALL NOT alter L or the pulses.
REQ-032 Macro STUCK_DETECT_EN undefined: stuck SHALL be constant 3'b000, and no stuck counters SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
REQ-033 walk_raw 0->1 sampled at edge 10 and held -> walk_level=1 from edge 15, with walk_pulse high only in the cycle after edge 15.
REQ-034 walk_raw high for cycles 10-12, low at 13, high again from 14 -> no level change before edge 19; exactly one pulse.
REQ-035 sel_raw=2'b10, value_raw=4'h7, prog_raw rises at edge 10 -> at edge 15 sel_out=2, value_out=7, param_strobe=1 for one cycle; then changing value_raw to 4'h3 leaves value_out=7.
REQ-036 sensor_raw high, reset pulsed low at edge 13 (mid-count) -> all outputs 0; after release the level rises 6 edges later with no earlier pulse.
REQ-037 With STUCK_DETECT_EN defined, sensor held high 40 cycles -> stuck[0]=1 twenty cycles after sensor_level rises; it clears on the edge sensor_level falls. Without the macro, stuck stays 0.
REQ-038 All three raw inputs rise at the same edge -> all three levels, walk_pulse and prog_pulse assert in the same cycle.
